// File: rtl/aes_key_expander_pkg.sv
// ------------------------------------------------------------------
// aes_pkg: shared constants, helpers and FSM encoding for key expansion
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam logic       AES_128   = 1'b0;
  localparam logic       AES_256   = 1'b1;
  localparam logic [3:0] NR_128    = 4'd10;
  localparam logic [3:0] NR_256    = 4'd14;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_GEN  = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_expander_word_step.sv
// ------------------------------------------------------------------
// aes_key_word_step: one round-key step, 4-word XOR chain with rot/rcon mux
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module aes_key_word_step
  import aes_pkg::*;
(
  input  logic [127:0] i_base,
  input  logic [31:0]  i_sub,
  input  logic [7:0]   i_rcon,
  input  logic         i_rot,
  output logic [127:0] o_rk
);

  logic [31:0] w_t;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;

  // S-box works bytewise, so rotating its result equals substituting a rotated word
  assign w_t  = i_rot ? (rotword(i_sub) ^ {i_rcon, 24'h0}) : i_sub;
  assign w_w0 = i_base[127:96] ^ w_t;
  assign w_w1 = i_base[95:64]  ^ w_w0;
  assign w_w2 = i_base[63:32]  ^ w_w1;
  assign w_w3 = i_base[31:0]   ^ w_w2;
  assign o_rk = {w_w0, w_w1, w_w2, w_w3};

endmodule

`default_nettype wire

// File: rtl/aes_key_expander.sv
// ------------------------------------------------------------------
// aes_key_expander: AES-128/256 round-key generator, one key per cycle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module aes_key_expander #(
  parameter int AES256_EN  = 1,
  parameter int MAX_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         keylen,
  input  logic [255:0] key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic [3:0]   num_rounds,
  output logic         ready
);

  import aes_pkg::*;

  state_t       r_state;
  state_t       w_next_state;
  logic [127:0] r_store [0:MAX_ROUNDS];
  logic [255:0] r_key;
  logic         r_mode;
  logic [7:0]   r_rcon;
  logic [3:0]   r_cnt;
  logic [3:0]   r_nr;

  logic         w_mode_sel;
  logic         w_last;
  logic         w_rot;
  logic [3:0]   w_prev_idx;
  logic [3:0]   w_base_idx;
  logic [127:0] w_prev_rk;
  logic [127:0] w_base_rk;
  logic [127:0] w_new_rk;

  assign w_mode_sel = (AES256_EN != 0) ? keylen : AES_128;
  assign w_last     = (r_cnt == r_nr);
  assign w_prev_idx = r_cnt - 4'd1;
  assign w_base_idx = (r_mode == AES_256) ? (r_cnt - 4'd2) : (r_cnt - 4'd1);
  assign w_prev_rk  = r_store[w_prev_idx];
  assign w_base_rk  = r_store[w_base_idx];
  // AES-256 alternates: even rounds rotate and use rcon, odd rounds only substitute
  assign w_rot      = (r_mode == AES_128) || !r_cnt[0];

  assign sboxw      = (r_state == ST_GEN) ? w_prev_rk[31:0] : 32'h0;
  assign ready      = (r_state == ST_IDLE);
  assign num_rounds = r_nr;
  assign round_key  = (round > r_nr) ? 128'h0 : r_store[round];

  aes_key_word_step u_step (
    .i_base (w_base_rk),
    .i_sub  (new_sboxw),
    .i_rcon (r_rcon),
    .i_rot  (w_rot),
    .o_rk   (w_new_rk)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (init) w_next_state = ST_INIT;
      ST_INIT: w_next_state = ST_GEN;
      ST_GEN:  if (w_last) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= MAX_ROUNDS; i++) r_store[i] <= 128'h0;
      r_key  <= 256'h0;
      r_mode <= AES_128;
      r_rcon <= 8'h00;
      r_cnt  <= 4'd0;
      r_nr   <= NR_128;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (init) begin
            r_key  <= key;
            r_mode <= w_mode_sel;
            r_nr   <= (w_mode_sel == AES_256) ? NR_256 : NR_128;
          end
        end
        ST_INIT: begin
          r_store[0] <= r_key[255:128];
          if (r_mode == AES_256) r_store[1] <= r_key[127:0];
          r_rcon <= RCON_INIT;
          r_cnt  <= (r_mode == AES_256) ? 4'd2 : 4'd1;
        end
        ST_GEN: begin
          r_store[r_cnt] <= w_new_rk;
          r_cnt          <= r_cnt + 4'd1;
          if (w_rot) r_rcon <= xtime(r_rcon);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expander.sv
// ------------------------------------------------------------------
// tb_aes_key_expander: directed and random checks against a FIPS-197 style model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic         keylen;
  logic [255:0] key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [3:0]   num_rounds;
  logic         ready;

  int           checks   = 0;
  int           failures = 0;
  logic [7:0]   sbox_tab [0:255];
  logic [31:0]  w_arr    [0:59];
  logic [127:0] exp_rk   [0:14];
  int           nr_exp;
  logic [127:0] rd;
  int           lat;

  localparam logic [255:0] KEY_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expander #(.AES256_EN(1), .MAX_ROUNDS(14)) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .keylen     (keylen),
    .key        (key),
    .sboxw      (sboxw),
    .new_sboxw  (new_sboxw),
    .round      (round),
    .round_key  (round_key),
    .num_rounds (num_rounds),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  always_comb new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                           sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse in GF(2^8) then affine map
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    if (x == 8'h00) v = 8'h00;
    else for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic model_expand(input logic kl, input logic [255:0] k);
    int         nk;
    int         rc;
    logic [31:0] tmp;
    nk     = kl ? 8 : 4;
    nr_exp = kl ? 14 : 10;
    rc     = 1;
    for (int i = 0; i < nk; i++) w_arr[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr_exp+1); i++) begin
      tmp = w_arr[i-1];
      if (i % nk == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc[7:0], 24'h0};
        rc  = rc * 2;
        if (rc > 255) rc = rc ^ 'h11b;
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subword(tmp);
      end
      w_arr[i] = w_arr[i-nk] ^ tmp;
    end
    for (int j = 0; j <= nr_exp; j++)
      exp_rk[j] = {w_arr[4*j], w_arr[4*j+1], w_arr[4*j+2], w_arr[4*j+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic read_rk(input int idx, output logic [127:0] v);
    @(negedge clk);
    round = idx[3:0];
    #1;
    v = round_key;
  endtask

  task automatic check_all(input string tag);
    logic [127:0] e;
    logic [127:0] v;
    for (int j = 0; j < 16; j++) begin
      e = 128'h0;
      if (j <= nr_exp) e = exp_rk[j];
      read_rk(j, v);
      chk($sformatf("%s_rk%0d", tag, j), v, e);
    end
  endtask

  // Start an expansion; scramble key/keylen while busy, optionally pulse init or reset.
  task automatic expand(input logic kl, input logic [255:0] k, input int pulse_at,
                        input int reset_at, output int l);
    @(negedge clk);
    keylen = kl;
    key    = k;
    init   = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    l    = -1;
    for (int n = 1; n <= 40; n++) begin
      key    = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
      keylen = 1'($urandom_range(0, 1));
      if (n == pulse_at) init = 1'b1;
      if (n == reset_at) reset = 1'b1;
      @(posedge clk);
      #1;
      init = 1'b0;
      if (n == reset_at || ready) begin
        l = n;
        break;
      end
    end
  endtask

  initial begin
    logic         kl;
    logic [255:0] k;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    reset = 1'b1; init = 1'b0; keylen = 1'b0; key = 256'h0; round = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 128'(ready), 128'd1);
    chk("rst_num_rounds", 128'(num_rounds), 128'd10);
    chk("rst_sboxw", 128'(sboxw), 128'h0);
    chk("rst_round_key", round_key, 128'h0);
    reset = 1'b0;

    // AES-128, zero key
    model_expand(1'b0, 256'h0);
    expand(1'b0, 256'h0, 0, 0, lat);
    chk("lat128_zero", 128'(lat), 128'd11);
    chk("num_rounds_128", 128'(num_rounds), 128'd10);
    chk("idle_sboxw", 128'(sboxw), 128'h0);
    read_rk(1, rd);  chk("z128_rk1_const", rd, 128'h62636363626363636263636362636363);
    read_rk(10, rd); chk("z128_rk10_const", rd, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check_all("z128");

    // AES-128, FIPS-197 key in the upper half
    k = {KEY_FIPS, 128'h0123456789abcdef0123456789abcdef};
    model_expand(1'b0, k);
    expand(1'b0, k, 0, 0, lat);
    read_rk(10, rd); chk("fips128_rk10_const", rd, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(11, rd); chk("fips128_rk11_zero", rd, 128'h0);
    check_all("fips128");

    // AES-256, sequential key
    model_expand(1'b1, KEY_SEQ);
    expand(1'b1, KEY_SEQ, 0, 0, lat);
    chk("lat256_seq", 128'(lat), 128'd14);
    chk("num_rounds_256", 128'(num_rounds), 128'd14);
    read_rk(14, rd); chk("seq256_rk14_const", rd, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    read_rk(1, rd);  chk("seq256_rk1_const", rd, 128'h101112131415161718191a1b1c1d1e1f);
    check_all("seq256");

    // AES-256, zero key
    model_expand(1'b1, 256'h0);
    expand(1'b1, 256'h0, 0, 0, lat);
    read_rk(2, rd); chk("z256_rk2_const", rd, 128'h62636363626363636263636362636363);
    read_rk(3, rd); chk("z256_rk3_const", rd, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);
    check_all("z256");

    // init pulsed mid-expansion must be ignored
    model_expand(1'b1, KEY_SEQ);
    expand(1'b1, KEY_SEQ, 5, 0, lat);
    chk("lat256_init_pulse", 128'(lat), 128'd14);
    check_all("pulse256");

    // reset mid-expansion aborts and clears the store
    expand(1'b1, KEY_SEQ, 0, 6, lat);
    chk("abort_edge", 128'(lat), 128'd6);
    chk("abort_ready", 128'(ready), 128'd1);
    chk("abort_num_rounds", 128'(num_rounds), 128'd10);
    for (int j = 0; j < 16; j++) begin
      read_rk(j, rd);
      chk($sformatf("abort_rk%0d", j), rd, 128'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_expand(1'b0, 256'h0);
    expand(1'b0, 256'h0, 0, 0, lat);
    chk("lat128_after_abort", 128'(lat), 128'd11);
    read_rk(10, rd); chk("after_abort_rk10", rd, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // random keys and modes, back-to-back
    for (int it = 0; it < 8; it++) begin
      kl = 1'($urandom_range(0, 1));
      k  = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      model_expand(kl, k);
      expand(kl, k, 0, 0, lat);
      chk($sformatf("rand%0d_lat", it), 128'(lat), kl ? 128'd14 : 128'd11);
      chk($sformatf("rand%0d_nr", it), 128'(num_rounds), 128'(nr_exp));
      check_all($sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
